uart_tx_word_arbiter: RTL and testbench
=======================================

// Module: uart_tx_word_arbiter
// PURPOSE
//  Shares the single byte-wide UART transmitter between NUM_REQ word producers
//  (core result stream, register-dump unit, status reporter).
//  - Grants whole 32-bit words round-robin and serializes each word LSB-first into
//    the UART tx_start/tx_data/tx_active handshake, optionally prefixed by a tag byte.
//  - Bytes from different requesters never interleave.
// PARAMETERS
//  NUM_REQ         2     number of requesters, 1..16
//  SEND_TAG        1     1: send tag byte 8'hA0|id before each word; 0: no tag
//  TIMEOUT_CYCLES  1023  max cycles tx_start may wait for tx_active, >=1
// PORTS
//  clk          in   1           system clock
//  rst          in   1           synchronous, active-high reset
//  req_valid    in   NUM_REQ     requester i has a word; held until req_ready[i]
//  req_data     in   32*NUM_REQ  word of requester i at [32*i+:32]; stable while valid
//  req_ready    out  NUM_REQ     one-cycle pulse: word of requester i captured
//  tx_active    in   1           UART transmitter busy
//  tx_data      out  8           byte to UART, stable while tx_start high
//  tx_start     out  1           byte request to UART
//  busy         out  1           word in flight (state != IDLE)
//  grant_id     out  4           id of the current/last granted requester
//  timeout_err  out  1           sticky: UART never answered a tx_start
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
//  Reset: state=IDLE; rr pointer=0.
//   - All outputs 0: req_ready, tx_data, tx_start, busy, grant_id, timeout_err.
//   - Reset mid-word: the partial word is dropped and tx_start deasserts on the next edge.
//  IDLE:
//   - If any req_valid and !tx_active: grant the first valid index at or after ptr (wrapping).
//   - Same cycle: pulse req_ready[g], latch req_data[g] into word_q, grant_id<=g,
//     ptr<=(g+1)%NUM_REQ, byte_cnt<=0, go to LOAD.
//   - No valid request: stay in IDLE; ptr is unchanged.
//  LOAD:
//   - tx_data <= tag (if SEND_TAG and byte_cnt==0) else word_q byte selected by the data index.
//   - Data index = byte_cnt-SEND_TAG; byte 0 = [7:0].
//   - Clear the timeout counter; go to REQ.
//  REQ:
//   - tx_start=1 and tx_data held.
//   - On tx_active==1: tx_start<=0, go to BUSY.
//   - Otherwise increment the timeout counter.
//   - Counter == TIMEOUT_CYCLES: timeout_err<=1, tx_start<=0, drop the rest of the word,
//     go to IDLE.
//  BUSY:
//   - Wait for tx_active==0.
//   - Then, if byte_cnt == 3+SEND_TAG go to IDLE; else byte_cnt++ and go to LOAD.
//  Word timing:
//   - 4+SEND_TAG bytes per word.
//   - Minimum 3 cycles per byte beyond UART time (LOAD, REQ, BUSY exit).
//   - Grant to first tx_start: 2 cycles.
//  Boundaries:
//   - A new grant needs IDLE and !tx_active, so a requester never sees req_ready while the
//     UART is busy.
//   - All requesters valid continuously: service order is 0,1,..,N-1,0 with no starvation.
//   - A requester dropping valid before grant is legal; it is not granted.
//   - Requester data must not change between valid and req_ready.
//   - tx_active already high when REQ is entered: accepted immediately as the handshake.
//   - timeout_err clears only on rst. After a timeout the block keeps arbitrating.
//   - byte_cnt is 3 bits and never exceeds 4.
//   - NUM_REQ==1: the pointer is constant 0.
// STRUCTURE
//  Package uart_arb_pkg:
//   - state_t {IDLE, LOAD, REQ, BUSY};
//   - TAG_PREFIX=8'hA0; WORD_BYTES=4; function tag_byte(id).
//  Sub-module rr_arbiter #(N):
//   - Inputs: req vector, ptr, advance.
//   - Outputs: onehot grant, grant index, found flag.
//   - Holds the pointer register.
//  Top: FSM, word latch, byte mux, timeout counter.
// TESTING
//  1. Reset, req0 valid with 32'h11223344, UART model with 5-cycle busy, SEND_TAG=1
//     -> bytes A0,44,33,22,11; one req_ready[0] pulse; busy low after the last byte.
//  2. req0 and req1 both valid (0xAAAA0000, 0x0000BBBB), held
//     -> order 0,1,0,1; words never interleaved; grant_id alternates.
//  3. UART model never raises tx_active
//     -> tx_start high exactly TIMEOUT_CYCLES+1 cycles, then low; timeout_err=1;
//        next request is still served.
//  4. tx_active held high externally while req1 valid
//     -> no req_ready until tx_active falls; then grant 2 cycles before tx_start.
//  5. rst asserted during the third data byte
//     -> next cycle: tx_start=0, busy=0, grant_id=0; the pending word is re-granted
//        from ptr 0.
//  6. SEND_TAG=0, NUM_REQ=3, only req2 valid with 32'hDEADBEEF
//     -> bytes EF,BE,AD,DE; grant_id=2; ptr wraps to 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types, constants and byte helpers for the UART word arbiter.
package uart_arb_pkg;

  // FSM encoding kept as plain 2-bit constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t REQ  = 2'd2;
  localparam state_t BUSY = 2'd3;

  localparam logic [7:0] TAG_PREFIX = 8'hA0;
  localparam int         WORD_BYTES = 4;

  // Tag byte sent ahead of a word: prefix in the high nibble, requester id in the low one.
  function automatic logic [7:0] tag_byte(input logic [3:0] id);
    return TAG_PREFIX | {4'h0, id};
  endfunction

  // Little-endian byte select: index 0 is bits [7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_word_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer
// (wrapping) and moves the pointer just past the winner when told to advance.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [3:0]   grant_idx,
  output logic         found
);

  logic [3:0] ptr_r;
  logic [3:0] idx_s;
  logic [3:0] next_ptr_s;
  logic [4:0] dist_s;
  logic [4:0] best_s;
  logic       found_s;

  // Find the valid requester with the smallest rotational distance from the pointer.
  always_comb begin
    found_s = 1'b0;
    idx_s   = 4'd0;
    best_s  = 5'd0;
    dist_s  = 5'd0;
    for (int i = 0; i < N; i++) begin
      if (5'(i) >= {1'b0, ptr_r}) begin
        dist_s = 5'(i) - {1'b0, ptr_r};
      end else begin
        dist_s = 5'(i) + 5'(N) - {1'b0, ptr_r};
      end
      if (req[i] && (!found_s || (dist_s < best_s))) begin
        found_s = 1'b1;
        best_s  = dist_s;
        idx_s   = 4'(i);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Expand the winning index into a one-hot grant vector.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = found_s && (idx_s == 4'(i));
    end
  end

  // With N==1 the wrap test is always true, so the pointer stays at 0.
  assign next_ptr_s = (idx_s == 4'(N - 1)) ? 4'd0 : (idx_s + 4'd1);
  assign grant_idx  = idx_s;
  assign found      = found_s;

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 4'd0;
    end else if (advance && found_s) begin
      ptr_r <= next_ptr_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/uart_tx_word_arbiter.sv
// Shares one byte-wide UART transmitter between NUM_REQ word producers.
// Whole 32-bit words are granted round-robin and sent LSB first, optionally
// preceded by a tag byte naming the requester; words never interleave.
module uart_tx_word_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int SEND_TAG       = 1,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  tx_active,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic [3:0]            grant_id,
  output logic                  timeout_err
);

  localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic       TAG_EN    = (SEND_TAG != 0);
  localparam logic [2:0] LAST_BYTE = 3'(WORD_BYTES - 1 + SEND_TAG);

  state_t             state_r;
  logic [31:0]        word_r;
  logic [2:0]         byte_cnt_r;
  logic [TW-1:0]      to_cnt_r;

  logic [NUM_REQ-1:0] grant_oh_s;
  logic [3:0]         grant_idx_s;
  logic               found_s;
  logic               advance_s;
  logic [31:0]        sel_word_s;
  logic [1:0]         data_idx_s;
  logic [7:0]         load_byte_s;

  // A new grant is only taken from IDLE while the UART is quiet.
  assign advance_s = (state_r == IDLE) && !tx_active;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (advance_s),
    .grant     (grant_oh_s),
    .grant_idx (grant_idx_s),
    .found     (found_s)
  );

  // AND-OR mux of the granted requester's word (grant is one-hot).
  always_comb begin
    sel_word_s = 32'h0000_0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_word_s = sel_word_s | (req_data[32*i +: 32] & {32{grant_oh_s[i]}});
    end
  end

  // Byte for the current slot: tag first when enabled, then data bytes LSB first.
  always_comb begin
    data_idx_s = 2'(byte_cnt_r - 3'(SEND_TAG));
    if (TAG_EN && (byte_cnt_r == 3'd0)) begin
      load_byte_s = tag_byte(grant_id);
    end else begin
      load_byte_s = word_byte(word_r, data_idx_s);
    end
  end

  // Main FSM: grant, load byte, handshake with timeout, wait for UART idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      word_r      <= 32'h0000_0000;
      byte_cnt_r  <= 3'd0;
      to_cnt_r    <= '0;
      req_ready   <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= 4'd0;
      timeout_err <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state_r)
        IDLE: begin
          if (found_s && !tx_active) begin
            req_ready  <= grant_oh_s;
            word_r     <= sel_word_s;
            grant_id   <= grant_idx_s;
            byte_cnt_r <= 3'd0;
            busy       <= 1'b1;
            state_r    <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          tx_data  <= load_byte_s;
          to_cnt_r <= '0;
          tx_start <= 1'b1;
          state_r  <= REQ;
        end
        REQ: begin
          // An already-high tx_active counts as the acknowledge.
          if (tx_active) begin
            tx_start <= 1'b0;
            state_r  <= BUSY;
          end else if (to_cnt_r == TW'(TIMEOUT_CYCLES)) begin
            // UART never answered: abandon the rest of this word.
            timeout_err <= 1'b1;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
          end
        end
        BUSY: begin
          if (!tx_active) begin
            if (byte_cnt_r == LAST_BYTE) begin
              busy    <= 1'b0;
              state_r <= IDLE;
            end else begin
              byte_cnt_r <= byte_cnt_r + 3'd1;
              state_r    <= LOAD;
            end
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          tx_start <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Scoreboard bench for uart_tx_word_arbiter: two instances (2 requesters with
// tag, 3 requesters without tag), each with a simple UART model and monitor.
module tb_uart_tx_word_arbiter;

  localparam int TO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: NUM_REQ=2, SEND_TAG=1
  logic [1:0]  a_valid;
  logic [63:0] a_data;
  logic [1:0]  a_ready;
  logic        a_active, a_start, a_busy, a_terr;
  logic [7:0]  a_txd;
  logic [3:0]  a_gid;
  // Instance B: NUM_REQ=3, SEND_TAG=0
  logic [2:0]  b_valid;
  logic [95:0] b_data;
  logic [2:0]  b_ready;
  logic        b_active, b_start, b_busy, b_terr;
  logic [7:0]  b_txd;
  logic [3:0]  b_gid;

  uart_tx_word_arbiter #(.NUM_REQ(2), .SEND_TAG(1), .TIMEOUT_CYCLES(TO)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
    .tx_active(a_active), .tx_data(a_txd), .tx_start(a_start), .busy(a_busy),
    .grant_id(a_gid), .timeout_err(a_terr));

  uart_tx_word_arbiter #(.NUM_REQ(3), .SEND_TAG(0), .TIMEOUT_CYCLES(TO)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
    .tx_active(b_active), .tx_data(b_txd), .tx_start(b_start), .busy(b_busy),
    .grant_id(b_gid), .timeout_err(b_terr));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected output %h, nothing expected at %0t", name, act, $time);
  endtask

  // UART models: 5-cycle busy per accepted byte; A can be muted or forced busy.
  logic       a_mact, b_mact, a_mute, a_force;
  logic [2:0] a_mcnt, b_mcnt;
  assign a_active = a_mact | a_force;
  assign b_active = b_mact;

  always @(posedge clk) begin
    if (rst) begin
      a_mact <= 1'b0; a_mcnt <= 3'd0;
    end else if (a_mact) begin
      a_mcnt <= a_mcnt - 3'd1;
      if (a_mcnt == 3'd1) a_mact <= 1'b0;
    end else if (a_start && !a_mute && !a_force) begin
      a_mact <= 1'b1; a_mcnt <= 3'd5;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      b_mact <= 1'b0; b_mcnt <= 3'd0;
    end else if (b_mact) begin
      b_mcnt <= b_mcnt - 3'd1;
      if (b_mcnt == 3'd1) b_mact <= 1'b0;
    end else if (b_start) begin
      b_mact <= 1'b1; b_mcnt <= 3'd5;
    end
  end

  // Scoreboards
  logic [7:0] a_exp_q[$];
  logic [7:0] b_exp_q[$];
  int         a_gnt_q[$];
  int         b_gnt_q[$];
  int a_bytes = 0, a_readys = 0, a_falls = 0, a_last_run = 0;
  int b_bytes = 0, b_readys = 0;

  // Monitor A: byte starts, data hold, tx_start run length, grant pulses.
  initial begin
    logic       prev;
    logic [7:0] hold;
    int         run;
    int         g;
    prev = 1'b0; hold = 8'h00; run = 0;
    forever begin
      @(negedge clk);
      if (a_start && !prev) begin
        a_bytes++;
        hold = a_txd;
        if (a_exp_q.size() == 0) unexpected("a_byte", 32'(a_txd));
        else check("a_byte", 32'(a_txd), 32'(a_exp_q.pop_front()));
      end else if (a_start && prev) begin
        check("a_txd_hold", 32'(a_txd), 32'(hold));
      end
      if (a_start) run++;
      else begin
        if (prev) begin a_last_run = run; a_falls++; end
        run = 0;
      end
      prev = a_start;
      if (a_ready != 2'b00) begin
        a_readys++;
        if (a_gnt_q.size() == 0) unexpected("a_ready", 32'(a_ready));
        else begin
          g = a_gnt_q.pop_front();
          check("a_ready_onehot", 32'(a_ready), 32'd1 << g);
          check("a_grant_id", 32'(a_gid), 32'(g));
          check("a_busy_at_grant", 32'(a_busy), 32'd1);
        end
      end
    end
  end

  // Monitor B: byte starts and grant pulses.
  initial begin
    logic prev;
    int   g;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (b_start && !prev) begin
        b_bytes++;
        if (b_exp_q.size() == 0) unexpected("b_byte", 32'(b_txd));
        else check("b_byte", 32'(b_txd), 32'(b_exp_q.pop_front()));
      end
      prev = b_start;
      if (b_ready != 3'b000) begin
        b_readys++;
        if (b_gnt_q.size() == 0) unexpected("b_ready", 32'(b_ready));
        else begin
          g = b_gnt_q.pop_front();
          check("b_ready_onehot", 32'(b_ready), 32'd1 << g);
          check("b_grant_id", 32'(b_gid), 32'(g));
        end
      end
    end
  end

  function automatic int count_of(input int sel);
    case (sel)
      0: return a_readys;
      1: return b_readys;
      2: return a_bytes;
      default: return b_bytes;
    endcase
  endfunction

  // Wait (bounded) until a monitor counter reaches target, then compare it.
  task automatic wait_count(input string name, input int sel, input int target);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (count_of(sel) >= target) break;
    end
    check(name, 32'(count_of(sel)), 32'(target));
  endtask

  // Wait (bounded) until all expected output is seen and the UART is idle.
  task automatic wait_drained(input string name, input int d);
    logic done;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (d == 0) done = (a_exp_q.size() == 0) && (a_gnt_q.size() == 0) && !a_start && !a_active;
      else        done = (b_exp_q.size() == 0) && (b_gnt_q.size() == 0) && !b_start && !b_active;
      if (done) break;
    end
    check(name, (d == 0) ? 32'(a_exp_q.size()) : 32'(b_exp_q.size()), 32'd0);
  endtask

  task automatic push_word_a(input int g, input logic [31:0] w);
    a_gnt_q.push_back(g);
    a_exp_q.push_back(8'hA0 | 8'(g));
    for (int k = 0; k < 4; k++) a_exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic push_word_b(input int g, input logic [31:0] w);
    b_gnt_q.push_back(g);
    for (int k = 0; k < 4; k++) b_exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1; a_valid = 2'b00; a_data = 64'h0; b_valid = 3'b000; b_data = 96'h0;
    a_mute = 1'b0; a_force = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_start", 32'(a_start), 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_a_gid", 32'(a_gid), 32'd0);
    check("rst_a_terr", 32'(a_terr), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_a_txd", 32'(a_txd), 32'd0);
    check("rst_b_start", 32'(b_start), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    rst = 1'b0;

    // 1: single word with tag
    a_data[31:0] = 32'h11223344;
    a_gnt_q.push_back(0);
    a_exp_q.push_back(8'hA0); a_exp_q.push_back(8'h44); a_exp_q.push_back(8'h33);
    a_exp_q.push_back(8'h22); a_exp_q.push_back(8'h11);
    a_valid = 2'b01;
    wait_count("t1_ready", 0, 1);
    a_valid = 2'b00;
    wait_drained("t1_drain", 0);
    check("t1_busy_last_byte", 32'(a_busy), 32'd1);
    @(negedge clk);
    check("t1_busy_low", 32'(a_busy), 32'd0);
    check("t1_one_ready", 32'(a_readys), 32'd1);

    // 2: both requesters held valid; reset puts the pointer back at 0
    do_reset();
    a_data = {32'h0000BBBB, 32'hAAAA0000};
    push_word_a(0, 32'hAAAA0000); push_word_a(1, 32'h0000BBBB);
    push_word_a(0, 32'hAAAA0000); push_word_a(1, 32'h0000BBBB);
    base = a_readys;
    a_valid = 2'b11;
    wait_count("t2_ready", 0, base + 4);
    a_valid = 2'b00;
    wait_drained("t2_drain", 0);

    // 3: UART never answers -> timeout, then still serves
    do_reset();
    a_mute = 1'b1;
    a_data[31:0] = 32'h01020304;
    a_gnt_q.push_back(0); a_exp_q.push_back(8'hA0);
    base = a_falls;
    a_valid = 2'b01;
    wait_count("t3_ready", 0, a_readys + 1);
    a_valid = 2'b00;
    for (int i = 0; i < 200; i++) begin
      if (a_falls != base) break;
      @(negedge clk);
    end
    check("t3_start_run", 32'(a_last_run), 32'(TO + 1));
    check("t3_timeout_err", 32'(a_terr), 32'd1);
    check("t3_busy_after", 32'(a_busy), 32'd0);
    a_mute = 1'b0;
    a_data[63:32] = 32'hCAFEF00D;
    push_word_a(1, 32'hCAFEF00D);
    base = a_readys;
    a_valid = 2'b10;
    wait_count("t3_ready2", 0, base + 1);
    a_valid = 2'b00;
    wait_drained("t3_drain", 0);
    check("t3_timeout_sticky", 32'(a_terr), 32'd1);

    // 4: tx_active held high blocks the grant
    do_reset();
    a_force = 1'b1;
    a_data[63:32] = 32'h0BADCAFE;
    base = a_readys;
    a_valid = 2'b10;
    repeat (10) @(negedge clk);
    check("t4_no_ready", 32'(a_readys), 32'(base));
    check("t4_not_busy", 32'(a_busy), 32'd0);
    push_word_a(1, 32'h0BADCAFE);
    a_force = 1'b0;
    @(negedge clk);
    check("t4_ready_pulse", 32'(a_ready), 32'd2);
    check("t4_start_not_yet", 32'(a_start), 32'd0);
    @(negedge clk);
    check("t4_start_2cyc", 32'(a_start), 32'd1);
    a_valid = 2'b00;
    wait_drained("t4_drain", 0);

    // 5: reset during the third data byte of requester 1
    do_reset();
    a_data[63:32] = 32'h55667788;
    push_word_a(1, 32'h55667788);
    base = a_bytes;
    a_valid = 2'b10;
    wait_count("t5_bytes", 2, base + 4);
    rst = 1'b1;
    a_exp_q.delete();
    @(negedge clk);
    check("t5_start_rst", 32'(a_start), 32'd0);
    check("t5_busy_rst", 32'(a_busy), 32'd0);
    check("t5_gid_rst", 32'(a_gid), 32'd0);
    check("t5_ready_rst", 32'(a_ready), 32'd0);
    push_word_a(1, 32'h55667788);
    base = a_readys;
    rst = 1'b0;
    wait_count("t5_regrant", 0, base + 1);
    a_valid = 2'b00;
    wait_drained("t5_drain", 0);

    // 6: instance B, no tag, requester 2 then pointer wraps to 0
    b_data[95:64] = 32'hDEADBEEF;
    b_gnt_q.push_back(2);
    b_exp_q.push_back(8'hEF); b_exp_q.push_back(8'hBE);
    b_exp_q.push_back(8'hAD); b_exp_q.push_back(8'hDE);
    base = b_readys;
    b_valid = 3'b100;
    wait_count("t6_ready", 1, base + 1);
    b_valid = 3'b000;
    wait_drained("t6_drain", 1);
    check("t6_gid", 32'(b_gid), 32'd2);
    b_data[31:0]  = 32'h76543210;
    b_data[63:32] = 32'h89ABCDEF;
    push_word_b(0, 32'h76543210); push_word_b(1, 32'h89ABCDEF);
    base = b_readys;
    b_valid = 3'b011;
    wait_count("t6_wrap_ready", 1, base + 2);
    b_valid = 3'b000;
    wait_drained("t6_wrap_drain", 1);
    check("t6_no_timeout", 32'(b_terr), 32'd0);

    check("a_grants_left", 32'(a_gnt_q.size()), 32'd0);
    check("b_grants_left", 32'(b_gnt_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
